alu_muldiv_seq: RTL
===================

// Module: alu_muldiv_seq
// PURPOSE
//  Multi-cycle 8-bit unsigned multiply/divide sequencer for the CDEC datapath.
//  Drives the combinational ALU's operand/op inputs and consumes its {S,Z,Cy} flags and result.
//  Performs shift-add multiply or restoring divide, one ALU operation per clock.
//  Sits beside the ALU; the ALU input mux selects this block while busy=1.
// PARAMETERS
//  W     8   datapath width; must equal the ALU width (8)
//  ITER  8   iterations per operation; must equal W
// PORTS
//  clk         in   1   system clock, all state on rising edge
//  reset       in   1   synchronous, active-high
//  start       in   1   request; sampled only in IDLE
//  op          in   1   0=multiply a*b, 1=divide a/b
//  a           in   8   multiplicand / dividend, sampled with start
//  b           in   8   multiplier / divisor, sampled with start
//  busy        out  1   1 whenever state!=IDLE
//  done        out  1   1-cycle pulse; results valid from this cycle
//  dz          out  1   divide-by-zero flag of last operation
//  res_hi      out  8   mul: product[15:8]; div: remainder
//  res_lo      out  8   mul: product[7:0];  div: quotient
//  alu_x       out  8   ALU X operand
//  alu_t       out  8   ALU T operand
//  alu_cy      out  1   ALU carry in
//  alu_op      out  5   ALU operation code
//  alu_flag    in   3   {S,Z,Cy} from ALU, same cycle
//  alu_result  in   8   ALU result, same cycle
// BEHAVIOUR
//  Reset: state=IDLE, cnt=0, busy=done=dz=0, res_hi=res_lo=0, internal regs 0.
//   Reset mid-operation aborts; no done pulse.
//  ALU outputs per state (all others 0; alu_op=5'b00000 in IDLE/DONE):
//   MUL_ADD: x=acc, t=md, op=01000 if mq[0] else 00001 (pass X, Cy=0).
//   MUL_SHR: x=acc, cy=c, op=11001.
//   DIV_SHL: x=rem, cy=q[7], op=11010.
//   DIV_SUB: x=rem, t=md, op=01011.
//  IDLE: start=1 latches operands.
//   op=0: acc=0, mq=b, md=a, cnt=0 -> MUL_ADD.
//   op=1, b!=0: rem=0, q=a, md=b, cnt=0 -> DIV_SHL.
//   op=1, b==0: res_lo=8'hFF, res_hi=a, dz=1 -> DONE (no ALU iterations).
//  MUL_ADD: acc<=alu_result; c<=alu_flag[0] -> MUL_SHR.
//  MUL_SHR: acc<=alu_result; mq<={acc[0],mq[7:1]}.
//   cnt==7: -> DONE, res_hi<={acc-next}, res_lo<=mq-next, dz<=0; else cnt++ -> MUL_ADD.
//  DIV_SHL: rem<=alu_result; q<={q[6:0],1'b0}; ov<=alu_flag[0] -> DIV_SUB.
//  DIV_SUB: if ov|alu_flag[0] (no borrow), rem<=alu_result and q[0]<=1; else rem unchanged.
//   cnt==7: -> DONE, res_hi<=rem-next, res_lo<=q-next, dz<=0; else cnt++ -> DIV_SHL.
//  DONE: done=1 for exactly this cycle -> IDLE.
//  Results and dz hold until the next accepted start updates them at its own DONE.
//  Latency from start-sampling edge to done: 17 cycles for mul and for div with b!=0; 1 cycle for div-by-zero.
//  start during busy (any non-IDLE state incl. DONE) is ignored; no queuing.
//  Changes on a/b after the start edge have no effect.
//  Arithmetic unsigned; mul never overflows 16 bits; div gives floor quotient, remainder<b.
// TESTING
//  mul 13*11 -> done at +17 cycles, {res_hi,res_lo}=16'h008F, dz=0.
//  mul 255*255 -> 16'hFE01; mul 0*200 -> 16'h0000; mul 1*255 -> 16'h00FF.
//  div 200/7 -> res_lo=8'h1C, res_hi=8'h04; div 255/1 -> 8'hFF r 8'h00; div 5/9 -> 8'h00 r 8'h05.
//  div 37/0 -> done 1 cycle after start, dz=1, res_lo=8'hFF, res_hi=8'h25; next valid op clears dz.
//  start pulsed with new operands at cycles +3 and +16 of a mul -> ignored; original result returned.
//  reset asserted at cycle +8 of a div -> busy=0, no done, outputs 0; new start then completes normally.

Source files
------------

// File: rtl/alu_muldiv_seq.sv
// Multi-cycle unsigned multiply/divide sequencer. Each operation runs on the
// external combinational ALU, one ALU operation per clock: shift-add multiply
// (ADD then SHR per bit) or restoring divide (SHL then SUB per bit).
module alu_muldiv_seq #(
  parameter int W    = 8,
  parameter int ITER = 8
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         start,
  input  logic         op,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  output logic         busy,
  output logic         done,
  output logic         dz,
  output logic [W-1:0] res_hi,
  output logic [W-1:0] res_lo,
  output logic [W-1:0] alu_x,
  output logic [W-1:0] alu_t,
  output logic         alu_cy,
  output logic [4:0]   alu_op,
  input  logic [2:0]   alu_flag,
  input  logic [W-1:0] alu_result
);

  localparam int CNT_W = $clog2(ITER);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    MUL_ADD = 3'd1,
    MUL_SHR = 3'd2,
    DIV_SHL = 3'd3,
    DIV_SUB = 3'd4,
    DONE    = 3'd5
  } state_t;

  state_t state_q, state_d;

  // acc_q doubles as the divide remainder, mq_q as the quotient and c_q as
  // the shifted-out overflow bit; multiply and divide never run together.
  logic [W-1:0]     acc_q, mq_q, md_q;
  logic             c_q;
  logic [CNT_W-1:0] cnt_q;
  logic [W-1:0]     res_hi_q, res_lo_q;
  logic             dz_q;

  logic             last_iter;
  logic             sub_ok;
  logic [W-1:0]     mq_shr_d, rem_d, q_d;

  // Only the carry flag is consumed; sign/zero are part of the ALU contract.
  logic unused_flags;
  assign unused_flags = ^alu_flag[2:1];

  assign last_iter = (cnt_q == CNT_W'(ITER - 1));
  assign mq_shr_d  = {acc_q[0], mq_q[W-1:1]};
  // A set overflow bit means the shifted remainder exceeds W bits and is
  // therefore larger than any divisor, so the subtraction always succeeds.
  assign sub_ok    = c_q | alu_flag[0];
  assign rem_d     = sub_ok ? alu_result : acc_q;
  assign q_d       = {mq_q[W-1:1], sub_ok};

  // State register
  always_ff @(posedge clk) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          if (!op)           state_d = MUL_ADD;
          else if (b == '0)  state_d = DONE;
          else               state_d = DIV_SHL;
        end
      end
      MUL_ADD: state_d = MUL_SHR;
      MUL_SHR: state_d = last_iter ? DONE : MUL_ADD;
      DIV_SHL: state_d = DIV_SUB;
      DIV_SUB: state_d = last_iter ? DONE : DIV_SHL;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Outputs: status and the ALU operand/op drive for the current step
  always_comb begin
    busy   = (state_q != IDLE);
    done   = (state_q == DONE);
    alu_x  = '0;
    alu_t  = '0;
    alu_cy = 1'b0;
    alu_op = 5'b00000;
    case (state_q)
      MUL_ADD: begin
        alu_x  = acc_q;
        alu_t  = md_q;
        alu_op = mq_q[0] ? 5'b01000 : 5'b00001;
      end
      MUL_SHR: begin
        alu_x  = acc_q;
        alu_cy = c_q;
        alu_op = 5'b11001;
      end
      DIV_SHL: begin
        alu_x  = acc_q;
        alu_cy = mq_q[W-1];
        alu_op = 5'b11010;
      end
      DIV_SUB: begin
        alu_x  = acc_q;
        alu_t  = md_q;
        alu_op = 5'b01011;
      end
      default: ;
    endcase
  end

  // Datapath: operand capture, per-step updates and result latching
  always_ff @(posedge clk) begin
    if (reset) begin
      acc_q    <= '0;
      mq_q     <= '0;
      md_q     <= '0;
      c_q      <= 1'b0;
      cnt_q    <= '0;
      res_hi_q <= '0;
      res_lo_q <= '0;
      dz_q     <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (start) begin
            cnt_q <= '0;
            c_q   <= 1'b0;
            if (!op) begin
              acc_q <= '0;
              mq_q  <= b;
              md_q  <= a;
            end else if (b != '0) begin
              acc_q <= '0;
              mq_q  <= a;
              md_q  <= b;
            end else begin
              res_lo_q <= '1;
              res_hi_q <= a;
              dz_q     <= 1'b1;
            end
          end
        end
        MUL_ADD: begin
          acc_q <= alu_result;
          c_q   <= alu_flag[0];
        end
        MUL_SHR: begin
          acc_q <= alu_result;
          mq_q  <= mq_shr_d;
          if (last_iter) begin
            res_hi_q <= alu_result;
            res_lo_q <= mq_shr_d;
            dz_q     <= 1'b0;
            cnt_q    <= '0;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        DIV_SHL: begin
          acc_q <= alu_result;
          mq_q  <= {mq_q[W-2:0], 1'b0};
          c_q   <= alu_flag[0];
        end
        DIV_SUB: begin
          acc_q <= rem_d;
          mq_q  <= q_d;
          if (last_iter) begin
            res_hi_q <= rem_d;
            res_lo_q <= q_d;
            dz_q     <= 1'b0;
            cnt_q    <= '0;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign res_hi = res_hi_q;
  assign res_lo = res_lo_q;
  assign dz     = dz_q;

endmodule
